keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Scans a 4x4 matrix keypad by driving its column lines and sampling its row lines. Each accepted key press is delivered to the calculator core as a single-cycle `key_valid` pulse with a 4-bit `key_code`. Debouncing is done at whole-sweep granularity: a key is accepted only after the same single key is seen on `DB_COUNT` consecutive sweeps. This block is the driving end of the button path: it generates the scan stimulus rather than passively filtering a level.

## Interface
- `SCAN_DIV`, default 50000: clock cycles each column is driven (dwell). Must be ≥ 4.
- `DB_COUNT`, default 10: number of consecutive identical sweeps required to accept a press or a release. Must be ≥ 1.
- `REPEAT_SWEEPS`, default 200: sweeps between auto-repeat pulses. Used only with `KEYPAD_AUTOREPEAT_EN`.
- `clock`  in  1: system clock.
- `resetn`  in  1: synchronous, active-low reset.
- `rows`  in  4: keypad row lines, active-low (externally pulled up), asynchronous.
- `cols`  out  4: column drive, active-low, exactly one bit low at all times.
- `key_code`  out  4: code of the last accepted key, {col_index[1:0], row_index[1:0]}.
- `key_valid`  out  1: one-cycle pulse per accepted press (and per repeat, if enabled).
- `key_held`  out  1: high while an accepted key remains debounced-pressed.

## Operation
- `rows` passes through a 2-flop synchronizer before any use.
- Column sequencer:
  - A dwell counter counts 0..SCAN_DIV-1.
  - `cols` rotates 1110 → 1101 → 1011 → 0111 → 1110 (column index 0..3).
  - Advance occurs when the dwell counter reaches SCAN_DIV-1.
- Sampling: on the last dwell cycle of column c, the inverted synchronized rows are stored into snapshot bits [4c+3:4c].
- Sweep end: the last dwell cycle of column 3. At sweep end, the full 16-bit snapshot is classified:
  - NONE: zero bits set.
  - ONE(k): exactly one bit set, k = 4c + r.
  - MULTI: two or more bits set.
- Debounce counter, `stable_cnt`:
  - The candidate is the classification of the current sweep.
  - If it equals the previous sweep's candidate (same class and same k), `stable_cnt` increments, saturating at DB_COUNT. Otherwise `stable_cnt` resets to 1.
- FSM states:
  - IDLE: on sweep end with candidate ONE(k) and `stable_cnt` reaching DB_COUNT, go to PRESSED, latch `key_code`=k, pulse `key_valid`.
  - PRESSED: `key_held`=1. On sweep end with candidate NONE and `stable_cnt` reaching DB_COUNT, go to IDLE.
  - PRESSED ignores ONE(j≠k) and MULTI. No second press is accepted without a debounced release first.
  - IDLE ignores MULTI; no pulse is generated.
- `key_code` holds its value after release until the next accept.
- When a state transition occurs, `stable_cnt` restarts from the current sweep.

## Timing
- Reset values: `cols`=1110, `key_code`=0, `key_valid`=0, `key_held`=0. Dwell counter, snapshot, `stable_cnt`, previous candidate and repeat counter all clear; the FSM enters IDLE.
- Reset mid-sweep or mid-press restarts scanning at column 0 with no pulse emitted.
- Sweep period is exactly 4·SCAN_DIV cycles.
- Row-to-sample latency is 2 cycles (synchronizer). A row change within the last 2 dwell cycles may miss that sample; this is acceptable.
- `key_valid` and the updated `key_code` appear in the cycle after the sweep-end cycle. `key_valid` is high for exactly 1 cycle.
- `key_held` rises in the same cycle as `key_valid`. It falls in the cycle after the release-accepting sweep end.
- Minimum press-to-pulse latency is DB_COUNT sweeps from the first sweep seeing the key, plus 1 cycle.

## Configuration
- Macro `KEYPAD_AUTOREPEAT_EN`.
- Defined:
  - In PRESSED, a repeat counter counts sweep ends, starting at 0 on entry.
  - Each time it reaches REPEAT_SWEEPS, a further `key_valid` pulse is emitted with an unchanged `key_code`, and the counter returns to 0.
  - The counter clears on leaving PRESSED.
- Undefined: exactly one pulse per press. No repeat counter logic is synthesized.

## Test plan
All scenarios use SCAN_DIV=4 and DB_COUNT=3, so one sweep is 16 cycles.
- Reset: hold `resetn`=0 for 3 cycles with `rows`=1111 → `cols`=1110, `key_code`=0, `key_valid`=0, `key_held`=0. `cols` then rotates every 4 cycles.
- Clean press: model a switch at column 2, row 1, held for 6 sweeps → one `key_valid` pulse with `key_code`=1001 after sweep 3, plus 1 cycle; `key_held`=1.
- Bounce: the same key alternates present/absent every sweep for 10 sweeps → no `key_valid`, `key_held`=0.
- Release and re-press: after an accept, release for 2 sweeps then press again → no new pulse, `key_held` stays 1. Release for 3 sweeps → `key_held`=0. Then press for 3 sweeps → a second pulse.
- Multi-key: keys 0 and 5 pressed together from IDLE for 8 sweeps → no pulse. Release key 5 → pulse with `key_code`=0000 after 3 sweeps.
- Reset mid-operation: assert `resetn`=0 at sweep 2 of a press → no pulse, outputs at reset values. The press then requires 3 full sweeps after reset.
- With `KEYPAD_AUTOREPEAT_EN` and REPEAT_SWEEPS=5: key held for 20 sweeps → pulses at accept, then at +5, +10 and +15 sweeps.

Source files
------------

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
// Drives the four active-low column lines of a 4x4 matrix keypad one at a time,
// samples the active-low row lines at the end of each column dwell and, once
// per full sweep, classifies the 16-bit snapshot as no key / one key / several
// keys. A single key seen on DB_COUNT consecutive sweeps is accepted and
// reported as a one-cycle key_valid pulse with key_code = {col[1:0], row[1:0]};
// a release must likewise be seen on DB_COUNT consecutive sweeps.
//
// Optional feature macro: KEYPAD_AUTOREPEAT_EN
//   defined   - while a key stays accepted, a further key_valid pulse is
//               emitted every REPEAT_SWEEPS sweeps.
//   undefined - exactly one pulse per press, no repeat logic.
// -----------------------------------------------------------------------------
module keypad_scanner #(
    parameter int SCAN_DIV      = 50000,
    parameter int DB_COUNT      = 10,
    parameter int REPEAT_SWEEPS = 200
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    // Reject configurations the sequencer and debouncer cannot honour.
    if (SCAN_DIV < 4 || DB_COUNT < 1 || REPEAT_SWEEPS < 1) begin : g_bad_params
        $error("keypad_scanner: SCAN_DIV >= 4, DB_COUNT >= 1, REPEAT_SWEEPS >= 1 required");
    end

    localparam int DWELL_W = $clog2(SCAN_DIV);
    localparam int DB_W    = $clog2(DB_COUNT + 1);

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]    DB_MAX     = DB_W'(DB_COUNT);
    localparam logic [DB_W-1:0]    DB_ONE     = DB_W'(1);

    // Snapshot classes; for anything other than CLS_ONE the key field is 0 so
    // that "same candidate" is a plain equality on {class, key}.
    localparam logic [1:0] CLS_NONE  = 2'd0;
    localparam logic [1:0] CLS_ONE   = 2'd1;
    localparam logic [1:0] CLS_MULTI = 2'd2;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PRESSED = 1'b1
    } state_t;

    // Count the set bits of a sweep snapshot and map them to a class.
    function automatic logic [1:0] snap_class(input logic [15:0] snap);
        logic [4:0] ones;
        ones = 5'd0;
        for (int i = 0; i < 16; i++) begin
            ones = ones + {4'd0, snap[i]};
        end
        if (ones == 5'd0) begin
            snap_class = CLS_NONE;
        end else if (ones == 5'd1) begin
            snap_class = CLS_ONE;
        end else begin
            snap_class = CLS_MULTI;
        end
    endfunction

    // Index of the highest set bit; only meaningful when exactly one is set.
    function automatic logic [3:0] snap_key(input logic [15:0] snap);
        snap_key = 4'd0;
        for (int i = 0; i < 16; i++) begin
            snap_key = snap[i] ? 4'(i) : snap_key;
        end
    endfunction

    logic [3:0]         rows_meta_r;
    logic [3:0]         rows_sync_r;
    logic [DWELL_W-1:0] dwell_cnt_r;
    logic [1:0]         col_idx_r;
    logic [3:0]         cols_r;
    logic [11:0]        snapshot_r;
    logic [1:0]         prev_cls_r;
    logic [3:0]         prev_key_r;
    logic [DB_W-1:0]    stable_cnt_r;
    state_t             state_r;
    state_t             state_nxt_s;
    logic [3:0]         key_code_r;
    logic               key_valid_r;
    logic               key_held_r;

    logic               last_dwell_s;
    logic               sweep_end_s;
    logic [15:0]        sweep_snap_s;
    logic [1:0]         cand_cls_s;
    logic [3:0]         cand_key_s;
    logic               same_cand_s;
    logic [DB_W-1:0]    cnt_nxt_s;
    logic               accept_s;
    logic               release_s;
    logic               repeat_s;

    // Two-flop synchronizer for the asynchronous row lines (idle = all high).
    always_ff @(posedge clock) begin
        if (!resetn) begin
            rows_meta_r <= 4'hF;
            rows_sync_r <= 4'hF;
        end else begin
            rows_meta_r <= rows;
            rows_sync_r <= rows_meta_r;
        end
    end

    assign last_dwell_s = (dwell_cnt_r == DWELL_LAST);
    assign sweep_end_s  = last_dwell_s && (col_idx_r == 2'd3);

    // Column sequencer: dwell counter plus one-cold column rotation.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            dwell_cnt_r <= {DWELL_W{1'b0}};
            col_idx_r   <= 2'd0;
            cols_r      <= 4'b1110;
        end else if (last_dwell_s) begin
            dwell_cnt_r <= {DWELL_W{1'b0}};
            col_idx_r   <= col_idx_r + 2'd1;
            cols_r      <= {cols_r[2:0], cols_r[3]};
        end else begin
            dwell_cnt_r <= dwell_cnt_r + DWELL_W'(1);
        end
    end

    // Capture columns 0..2 into the snapshot; column 3 is consumed live.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            snapshot_r <= 12'h000;
        end else if (last_dwell_s) begin
            case (col_idx_r)
                2'd0:    snapshot_r[3:0]  <= ~rows_sync_r;
                2'd1:    snapshot_r[7:4]  <= ~rows_sync_r;
                2'd2:    snapshot_r[11:8] <= ~rows_sync_r;
                default: snapshot_r       <= snapshot_r;
            endcase
        end else begin
            snapshot_r <= snapshot_r;
        end
    end

    // Classify the complete sweep (column 3 taken straight from the synchronizer).
    always_comb begin
        sweep_snap_s = {~rows_sync_r, snapshot_r};
        cand_cls_s   = snap_class(sweep_snap_s);
        if (cand_cls_s == CLS_ONE) begin
            cand_key_s = snap_key(sweep_snap_s);
        end else begin
            cand_key_s = 4'd0;
        end
        same_cand_s = (cand_cls_s == prev_cls_r) && (cand_key_s == prev_key_r);
        if (!same_cand_s) begin
            cnt_nxt_s = DB_ONE;
        end else if (stable_cnt_r == DB_MAX) begin
            cnt_nxt_s = DB_MAX;
        end else begin
            cnt_nxt_s = stable_cnt_r + DB_ONE;
        end
    end

    // Press/release decisions, taken only at sweep end.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        release_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (sweep_end_s && (cand_cls_s == CLS_ONE) && (cnt_nxt_s == DB_MAX)) begin
                    state_nxt_s = ST_PRESSED;
                    accept_s    = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PRESSED: begin
                if (sweep_end_s && (cand_cls_s == CLS_NONE) && (cnt_nxt_s == DB_MAX)) begin
                    state_nxt_s = ST_IDLE;
                    release_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_PRESSED;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Sweep-to-sweep debounce history; a state change restarts the count
    // with the current sweep as the first one.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            prev_cls_r   <= CLS_NONE;
            prev_key_r   <= 4'd0;
            stable_cnt_r <= {DB_W{1'b0}};
        end else if (sweep_end_s) begin
            prev_cls_r   <= cand_cls_s;
            prev_key_r   <= cand_key_s;
            stable_cnt_r <= (accept_s || release_s) ? DB_ONE : cnt_nxt_s;
        end else begin
            prev_cls_r   <= prev_cls_r;
            prev_key_r   <= prev_key_r;
            stable_cnt_r <= stable_cnt_r;
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int REP_W = $clog2(REPEAT_SWEEPS + 1);
    localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_SWEEPS);

    logic [REP_W-1:0] rep_cnt_r;
    logic [REP_W-1:0] rep_nxt_s;

    // Count sweeps spent pressed; every REPEAT_SWEEPS of them fire a repeat.
    always_comb begin
        rep_nxt_s = rep_cnt_r;
        repeat_s  = 1'b0;
        if ((state_r != ST_PRESSED) || release_s) begin
            rep_nxt_s = {REP_W{1'b0}};
        end else if (sweep_end_s) begin
            if ((rep_cnt_r + REP_W'(1)) == REP_MAX) begin
                rep_nxt_s = {REP_W{1'b0}};
                repeat_s  = 1'b1;
            end else begin
                rep_nxt_s = rep_cnt_r + REP_W'(1);
            end
        end else begin
            rep_nxt_s = rep_cnt_r;
        end
    end

    // Repeat counter register.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            rep_cnt_r <= {REP_W{1'b0}};
        end else begin
            rep_cnt_r <= rep_nxt_s;
        end
    end
`else
    assign repeat_s = 1'b0;
`endif

    // Registered outputs: pulse and held flag land the cycle after sweep end.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            key_code_r  <= 4'd0;
            key_valid_r <= 1'b0;
            key_held_r  <= 1'b0;
        end else begin
            key_code_r  <= accept_s ? cand_key_s : key_code_r;
            key_valid_r <= accept_s || repeat_s;
            key_held_r  <= (state_nxt_s == ST_PRESSED);
        end
    end

    assign cols      = cols_r;
    assign key_code  = key_code_r;
    assign key_valid = key_valid_r;
    assign key_held  = key_held_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
// Directed scenarios followed by random key patterns. A switch-matrix model
// turns the pressed-key mask into row levels from the driven columns. The
// expected outputs come from a sweep-level model that keeps the candidate
// history since the last accepted press/release in a queue.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

    localparam int SCAN_DIV      = 4;
    localparam int DB_COUNT      = 3;
    localparam int REPEAT_SWEEPS = 5;
    localparam int SWEEP         = 4 * SCAN_DIV;

    logic        clock = 1'b0;
    logic        resetn;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;

    logic [15:0] key_mask = 16'h0000;

    int n_assert = 0;
    int n_fail   = 0;
    int pulses   = 0;

    // Reference model state.
    int   hist[$];
    logic m_held;
    logic [3:0] m_code;
    logic exp_pulse;
    int   rep_n;

    keypad_scanner #(
        .SCAN_DIV     (SCAN_DIV),
        .DB_COUNT     (DB_COUNT),
        .REPEAT_SWEEPS(REPEAT_SWEEPS)
    ) dut (
        .clock    (clock),
        .resetn   (resetn),
        .rows     (rows),
        .cols     (cols),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    always #5 clock = ~clock;

    // Switch matrix: a pressed key at (c, r) pulls row r low while column c is low.
    always_comb begin
        rows = 4'hF;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (key_mask[4 * c + r] && !cols[c]) rows[r] = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // -1 = no key, 0..15 = single key index, 16 = several keys.
    function automatic int cand_of(input logic [15:0] m);
        int n;
        n = $countones(m);
        if (n == 0) return -1;
        if (n > 1) return 16;
        for (int i = 0; i < 16; i++) begin
            if (m[i]) return i;
        end
        return -1;
    endfunction

    // Advance the reference model by one complete sweep that saw mask m.
    task automatic model_sweep(input logic [15:0] m);
        int c;
        int run;
        int idx;
        c = cand_of(m);
        hist.push_back(c);
        if (hist.size() > DB_COUNT) void'(hist.pop_front());
        run = 0;
        idx = hist.size() - 1;
        while (idx >= 0) begin
            if (hist[idx] != c) break;
            run++;
            idx--;
        end
        exp_pulse = 1'b0;
        if (!m_held) begin
            if (c >= 0 && c < 16 && run >= DB_COUNT) begin
                m_held    = 1'b1;
                m_code    = 4'(c);
                exp_pulse = 1'b1;
                rep_n     = 0;
                hist      = {c};
            end
        end else begin
            if (c < 0 && run >= DB_COUNT) begin
                m_held = 1'b0;
                hist   = {c};
            end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
                rep_n++;
                if (rep_n == REPEAT_SWEEPS) begin
                    exp_pulse = 1'b1;
                    rep_n     = 0;
                end
`endif
            end
        end
    endtask

    // Run ncyc cycles of a sweep with mask m, checking every cycle.
    task automatic run_sweep(input logic [15:0] m, input int ncyc);
        logic [3:0] exp_cols;
        key_mask = m;
        for (int i = 0; i < ncyc; i++) begin
            exp_cols = ~(4'b0001 << (i / SCAN_DIV));
            check("cols", cols, exp_cols);
            check("key_valid", {3'b000, key_valid}, {3'b000, (i == 0) ? exp_pulse : 1'b0});
            check("key_code", key_code, m_code);
            check("key_held", {3'b000, key_held}, {3'b000, m_held});
            if (key_valid === 1'b1) pulses++;
            @(posedge clock);
            #1;
        end
        exp_pulse = 1'b0;
        if (ncyc == SWEEP) model_sweep(m);
    endtask

    task automatic sweeps(input logic [15:0] m, input int n);
        for (int s = 0; s < n; s++) run_sweep(m, SWEEP);
    endtask

    task automatic do_reset(input int ncyc, input logic [15:0] m);
        resetn   = 1'b0;
        key_mask = m;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clock);
            #1;
            check("rst_valid", {3'b000, key_valid}, 4'h0);
        end
        check("rst_cols", cols, 4'b1110);
        check("rst_code", key_code, 4'h0);
        check("rst_held", {3'b000, key_held}, 4'h0);
        resetn    = 1'b1;
        m_held    = 1'b0;
        m_code    = 4'h0;
        exp_pulse = 1'b0;
        rep_n     = 0;
        hist.delete();
    endtask

    localparam logic [15:0] K9   = 16'h0200;  // column 2, row 1
    localparam logic [15:0] K0   = 16'h0001;
    localparam logic [15:0] K0K5 = 16'h0021;

    initial begin
        int p0;
        int len;
        int kind;
        logic [15:0] m;

        resetn = 1'b0;
        do_reset(3, 16'h0000);

        // Clean press held for 6 sweeps.
        p0 = pulses;
        sweeps(K9, 6);
        check_int("clean_pulses", pulses - p0, 1);
        check("clean_code", key_code, 4'b1001);
        check("clean_held", {3'b000, key_held}, 4'h1);
        sweeps(16'h0000, 4);
        check("release_held", {3'b000, key_held}, 4'h0);

        // Bounce: present/absent on alternate sweeps.
        p0 = pulses;
        for (int i = 0; i < 10; i++) run_sweep((i % 2 == 0) ? K9 : 16'h0000, SWEEP);
        check_int("bounce_pulses", pulses - p0, 0);
        check("bounce_held", {3'b000, key_held}, 4'h0);
        sweeps(16'h0000, 3);

        // Accept, short release, re-press, then a real release and re-press.
        p0 = pulses;
        sweeps(K9, 3);
        sweeps(16'h0000, 2);
        sweeps(K9, 3);
        check_int("short_release_pulses", pulses - p0, 1);
        check("short_release_held", {3'b000, key_held}, 4'h1);
        sweeps(16'h0000, 3);
        check("long_release_held", {3'b000, key_held}, 4'h0);
        p0 = pulses;
        sweeps(K9, 4);
        check_int("repress_pulses", pulses - p0, 1);
        sweeps(16'h0000, 4);

        // Two keys together, then one of them released.
        p0 = pulses;
        sweeps(K0K5, 8);
        check_int("multi_pulses", pulses - p0, 0);
        check("multi_held", {3'b000, key_held}, 4'h0);
        sweeps(K0, 4);
        check_int("multi_to_one_pulses", pulses - p0, 1);
        check("multi_to_one_code", key_code, 4'b0000);
        sweeps(16'h0000, 4);

        // Reset during the second sweep of a press.
        p0 = pulses;
        run_sweep(K9, SWEEP);
        run_sweep(K9, 8);
        do_reset(3, K9);
        sweeps(K9, 2);
        check_int("post_reset_early", pulses - p0, 0);
        sweeps(K9, 2);
        check_int("post_reset_pulses", pulses - p0, 1);
        sweeps(16'h0000, 4);

        // Long hold: auto-repeat pulses when enabled, a single pulse otherwise.
        p0 = pulses;
        sweeps(K9, 20);
`ifdef KEYPAD_AUTOREPEAT_EN
        check_int("hold20_pulses", pulses - p0, 4);
`else
        check_int("hold20_pulses", pulses - p0, 1);
`endif
        sweeps(16'h0000, 4);

        // Random key patterns.
        for (int seg = 0; seg < 40; seg++) begin
            kind = $urandom_range(0, 9);
            len  = $urandom_range(1, 5);
            if (kind < 4) begin
                m = 16'h0000;
            end else if (kind < 8) begin
                m = 16'h0001 << $urandom_range(0, 15);
            end else begin
                m = 16'($urandom);
                if ($countones(m) < 2) m = m | 16'h8001;
            end
            sweeps(m, len);
        end
        sweeps(16'h0000, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
